seg7_animator: RTL and testbench
================================

# seg7_animator

Sequenced, parametrised 7-segment animation engine for multi-digit displays. It owns the animation timebase, the per-mode frame sequencing (forward/reverse, hold, mode switching) and time-multiplexed digit scanning. It drives the output pins directly from registered segment and digit-enable signals. Segment bit order throughout: [0]=a top, [1]=b upper-right, [2]=c lower-right, [3]=d bottom, [4]=e lower-left, [5]=f upper-left, [6]=g middle; 1 = lit.

## Interface
- NUM_DIGITS, 2: digits scanned (1..4); mode 0 counts decimal over all digits.
- DIV_W, 20: prescaler width (>=5); sets the animation step period.
- SCAN_W, 10: scan counter width (>=1); each digit is shown for 2^SCAN_W cycles.
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  1 = animate, 0 = freeze frame state (scanning continues).
- dir  in  1  1 = forward, 0 = reverse.
- animation  in  3  mode select: 0 decimal count, 1 ring chase, 2 bounce, 3 blink, 4-7 blank.
- speed  in  4  step period = (speed+1)·2^(DIV_W-4) cycles.
- segments  out  7  registered segment pattern of the currently scanned digit.
- digit_en  out  NUM_DIGITS  registered one-hot digit select, active-high.
- frame_tick  out  1  registered 1-cycle pulse on every frame step.

## Operation
- Control FSM states: SWITCH, RUN, HOLD. Reset enters SWITCH.
  - SWITCH: lasts one cycle. Clears frame state (frame index 0, all BCD digits 0), loads the prescaler with reload = {speed, all-ones}, latches animation into mode_q, and blanks segments. It then goes to RUN if run=1, else HOLD.
  - RUN/HOLD: follow run each cycle. Any animation != mode_q goes to SWITCH; this takes priority over a same-cycle tick.
- Prescaler (RUN only): decrements each cycle. At 0 it asserts a tick, reloads with the current speed, and steps the frame. HOLD keeps both prescaler and frame unchanged.
- Mode 0, decimal: NUM_DIGITS BCD digits, digit 0 least significant.
  - Forward: +1 with carry; all 9s wraps to all 0s.
  - Reverse: −1 with borrow; all 0s wraps to all 9s.
  - Glyphs 0-9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
- Mode 1, ring chase: frame k in 0..5 shows 1<<k (g never lit). Forward 5→0, reverse 0→5.
- Mode 2, bounce: 6-frame sequence 1000001, 0100010, 0010100, 0001000, 0010100, 0100010, then repeats. Reverse walks the sequence backwards.
- Mode 3, blink: frame 0/1 shows 1111111/0000000. dir is ignored.
- Modes 4-7: segments 0, no frame steps, frame_tick stays 0.
- Modes 1-3 show the same pattern on every digit.
- Scan: the scan counter increments every cycle. When it is all-ones, the digit index advances, wrapping at NUM_DIGITS−1. NUM_DIGITS=1 gives digit_en constant 1 after reset.

## Timing
- Reset values: segments=0, digit_en=0, frame_tick=0. Frame state, scan counter, digit index and mode_q = 0.
- Outputs are registered: segments/digit_en reflect digit index and frame state with 1-cycle latency. frame_tick rises the cycle after the stepping tick, coincident with the new pattern for the scanned digit.
- First tick comes (reload+1) cycles after SWITCH.
- speed changes take effect at the next reload only.
- run falling in a tick cycle: the tick completes; the freeze starts the next cycle.
- rst_n assertion mid-operation clears everything immediately, with outputs 0 asynchronously. Release behaves like power-up.

## Structure
- Package seg7_pkg holds:
  - mode encodings (MODE_DEC, MODE_RING, MODE_BOUNCE, MODE_BLINK);
  - segment constants and the BCD glyph table;
  - per-mode frame lengths (10/6/6/2).
- One combinational sub-module, seg7_glyph (mode, frame index, BCD digit → 7 bits), instantiated once on the scan-selected digit. Prescaler, FSM, BCD counter and scanner live in seg7_animator.

## Test plan
All cases use NUM_DIGITS=2, DIV_W=6, SCAN_W=2, speed=0, so the step period is 4 cycles.
- Reset, mode 0: outputs 0 during reset. After release: 1 blank SWITCH cycle, then digit_en 01/10 alternating every 4 cycles, both digits 0111111.
- Mode 0, dir=1, 10 ticks: digit 1 = 0000110, digit 0 = 0111111, 10 frame_tick pulses. At 100 ticks both digits wrap to 0111111.
- Mode 0, dir=0, first tick: both digits 1101111 (99).
- Mode 2, dir=1, 7 ticks: sequence 0100010, 0010100, 0001000, 0010100, 0100010, 1000001, 0100010. With dir=0 the first tick gives 0100010 via frame 5.
- Mode change 1→3 in a tick cycle: no step, one blank cycle, then 1111111. run=0 for 20 cycles leaves the pattern unchanged with frame_tick=0.
- rst_n pulsed low mid-count (value 37): outputs 0 immediately. After release the count restarts at 00.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared encodings, glyph tables and FSM state type for the 7-segment animator.
// Segment vectors are {g, f, e, d, c, b, a}.
package seg7_pkg;

    localparam logic [2:0] MODE_DEC    = 3'd0;
    localparam logic [2:0] MODE_RING   = 3'd1;
    localparam logic [2:0] MODE_BOUNCE = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;

    localparam int unsigned FRAME_W = 3;

    localparam int unsigned LEN_DEC    = 10;
    localparam int unsigned LEN_RING   = 6;
    localparam int unsigned LEN_BOUNCE = 6;
    localparam int unsigned LEN_BLINK  = 2;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ALL   = 7'b1111111;

    // Entry 9 is listed first so that BCD_GLYPH[n] is the glyph for n.
    localparam logic [9:0][6:0] BCD_GLYPH = {
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    localparam logic [5:0][6:0] BOUNCE_SEQ = {
        7'b0100010, 7'b0010100, 7'b0001000, 7'b0010100, 7'b0100010, 7'b1000001
    };

    typedef enum logic [1:0] {
        StSwitch,
        StRun,
        StHold
    } ctrl_state_e;

    function automatic logic [FRAME_W-1:0] frame_last(input logic [2:0] mode);
        case (mode)
            MODE_RING:   return FRAME_W'(LEN_RING - 1);
            MODE_BOUNCE: return FRAME_W'(LEN_BOUNCE - 1);
            MODE_BLINK:  return FRAME_W'(LEN_BLINK - 1);
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Maps mode, frame index and one BCD digit to a 7-segment pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [2:0]         mode,
    input  logic [FRAME_W-1:0] frame,
    input  logic [3:0]         bcd,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (mode)
            MODE_DEC: begin
                if (bcd < 4'd10) seg = BCD_GLYPH[bcd];
            end
            MODE_RING: begin
                if (frame < 3'd6) seg = 7'd1 << frame;
            end
            MODE_BOUNCE: begin
                if (frame < 3'd6) seg = BOUNCE_SEQ[frame];
            end
            MODE_BLINK: seg = frame[0] ? SEG_BLANK : SEG_ALL;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_animator.sv
// Multi-digit 7-segment animation engine: control FSM, prescaler, BCD/frame
// sequencing and time-multiplexed digit scanning with registered outputs.
module seg7_animator
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned DIV_W      = 20,
    parameter int unsigned SCAN_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  dir,
    input  logic [2:0]            animation,
    input  logic [3:0]            speed,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    ctrl_state_e                state_q, state_d;
    logic [2:0]                 mode_q, mode_d;
    logic [DIV_W-1:0]           presc_q, presc_d, reload;
    logic [FRAME_W-1:0]         frame_q, frame_d, last;
    logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [SCAN_W-1:0]          scan_q;
    logic [IDX_W-1:0]           dig_q;
    logic [6:0]                 seg_q, seg_d, glyph;
    logic [NUM_DIGITS-1:0]      en_q, en_d;
    logic                       tick_q, step, carry;

    assign reload = {speed, {(DIV_W - 4){1'b1}}};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        frame_d = frame_q;
        bcd_d   = bcd_q;
        step    = 1'b0;
        carry   = 1'b0;
        last    = frame_last(mode_q);

        unique case (state_q)
            StSwitch: begin
                frame_d = '0;
                bcd_d   = '0;
                presc_d = reload;
                mode_d  = animation;
                state_d = run ? StRun : StHold;
            end
            StRun, StHold: begin
                // A mode change wins over a tick landing in the same cycle.
                if (animation != mode_q) begin
                    state_d = StSwitch;
                end else begin
                    state_d = run ? StRun : StHold;
                    if (state_q == StRun) begin
                        if (presc_q == '0) begin
                            presc_d = reload;
                            step    = (mode_q <= MODE_BLINK);
                        end else begin
                            presc_d = presc_q - DIV_W'(1);
                        end
                    end
                end
            end
            default: state_d = StSwitch;
        endcase

        if (step) begin
            if (mode_q == MODE_DEC) begin
                carry = 1'b1;
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (carry) begin
                        if (dir) begin
                            if (bcd_q[i] == 4'd9) begin
                                bcd_d[i] = 4'd0;
                            end else begin
                                bcd_d[i] = bcd_q[i] + 4'd1;
                                carry    = 1'b0;
                            end
                        end else begin
                            if (bcd_q[i] == 4'd0) begin
                                bcd_d[i] = 4'd9;
                            end else begin
                                bcd_d[i] = bcd_q[i] - 4'd1;
                                carry    = 1'b0;
                            end
                        end
                    end
                end
            end else if (dir) begin
                frame_d = (frame_q == last) ? '0 : frame_q + FRAME_W'(1);
            end else begin
                frame_d = (frame_q == '0) ? last : frame_q - FRAME_W'(1);
            end
        end
    end

    // Glyph looks at next-state frame data so the new pattern lines up with frame_tick.
    seg7_glyph u_glyph (
        .mode  (mode_q),
        .frame (frame_d),
        .bcd   (bcd_d[dig_q]),
        .seg   (glyph)
    );

    assign seg_d = (state_q == StSwitch) ? SEG_BLANK : glyph;
    assign en_d  = NUM_DIGITS'(1) << dig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSwitch;
            mode_q  <= '0;
            presc_q <= '0;
            frame_q <= '0;
            bcd_q   <= '0;
            scan_q  <= '0;
            dig_q   <= '0;
            seg_q   <= '0;
            en_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            frame_q <= frame_d;
            bcd_q   <= bcd_d;
            scan_q  <= scan_q + SCAN_W'(1);
            if (&scan_q) begin
                dig_q <= (dig_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_q + IDX_W'(1);
            end
            seg_q   <= seg_d;
            en_q    <= en_d;
            tick_q  <= step;
        end
    end

    assign segments   = seg_q;
    assign digit_en   = en_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_animator.sv
// Self-checking bench for seg7_animator: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model built from integer counters.
module tb_seg7_animator;

    localparam int unsigned ND = 2;
    localparam int unsigned DW = 6;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          dir;
    logic [2:0]    animation;
    logic [3:0]    speed;
    logic [6:0]    segments;
    logic [ND-1:0] digit_en;
    logic          frame_tick;

    seg7_animator #(
        .NUM_DIGITS (ND),
        .DIV_W      (DW),
        .SCAN_W     (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .dir        (dir),
        .animation  (animation),
        .speed      (speed),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0] digit_glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                     7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                     7'b1111111, 7'b1101111};
    logic [6:0] bounce_pat [6] = '{7'b1000001, 7'b0100010, 7'b0010100,
                                   7'b0001000, 7'b0010100, 7'b0100010};

    // Reference model: displayed count as an integer 0..99, frame as an integer.
    bit         m_switch;
    bit         m_running;
    int         m_mode, m_cnt, m_value, m_frame, m_edges;
    logic [6:0] e_seg;
    logic [1:0] e_en;
    logic       e_tick;
    int         ticks_seen;
    logic [6:0] shown [2];

    function automatic logic [6:0] ref_pattern(int mode, int frame, int value, int digit);
        case (mode)
            0:       return digit_glyph[(digit == 0) ? value % 10 : value / 10];
            1:       return 7'(1 << frame);
            2:       return bounce_pat[frame];
            3:       return (frame == 0) ? 7'h7f : 7'h00;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_switch   = 1'b1;
        m_running  = 1'b0;
        m_mode     = 0;
        m_cnt      = 0;
        m_value    = 0;
        m_frame    = 0;
        m_edges    = 0;
        e_seg      = '0;
        e_en       = '0;
        e_tick     = 1'b0;
        ticks_seen = 0;
        shown[0]   = '0;
        shown[1]   = '0;
    endtask

    // Predicts the outputs after the coming rising edge from the current inputs.
    task automatic model_edge();
        int reload;
        int digit;
        reload = int'(speed) * 4 + 3;
        digit  = (m_edges / 4) % 2;
        e_tick = 1'b0;
        if (m_switch) begin
            m_switch  = 1'b0;
            m_frame   = 0;
            m_value   = 0;
            m_cnt     = reload;
            m_mode    = int'(animation);
            m_running = run;
            e_seg     = 7'h00;
        end else begin
            if (int'(animation) != m_mode) begin
                m_switch = 1'b1;
            end else begin
                if (m_running) begin
                    if (m_cnt == 0) begin
                        m_cnt = reload;
                        if (m_mode < 4) begin
                            e_tick = 1'b1;
                            case (m_mode)
                                0: m_value = dir ? (m_value + 1) % 100 : (m_value + 99) % 100;
                                3: m_frame = 1 - m_frame;
                                default: m_frame = dir ? (m_frame + 1) % 6 : (m_frame + 5) % 6;
                            endcase
                        end
                    end else begin
                        m_cnt--;
                    end
                end
                m_running = run;
            end
            e_seg = ref_pattern(m_mode, m_frame, m_value, digit);
        end
        e_en = 2'(1 << digit);
        m_edges++;
    endtask

    task automatic step_cycle();
        model_edge();
        @(negedge clk);
        check_eq("segments", 32'(segments), 32'(e_seg));
        check_eq("digit_en", 32'(digit_en), 32'(e_en));
        check_eq("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (frame_tick) ticks_seen++;
        if (digit_en == 2'b01) shown[0] = segments;
        else if (digit_en == 2'b10) shown[1] = segments;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    // Asynchronous reset mid-cycle, released on the following falling edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_seg", 32'(segments), 32'h0);
        check_eq("arst_en", 32'(digit_en), 32'h0);
        check_eq("arst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] got_b [7];
        logic [6:0] exp_b [7];
        int nb;
        int base;

        exp_b = '{7'b0100010, 7'b0010100, 7'b0001000, 7'b0010100,
                  7'b0100010, 7'b1000001, 7'b0100010};
        rst_n = 1'b0; run = 1'b1; dir = 1'b1; animation = 3'd0; speed = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_seg", 32'(segments), 32'h0);
        check_eq("reset_en", 32'(digit_en), 32'h0);
        check_eq("reset_tick", 32'(frame_tick), 32'h0);

        rst_n = 1'b1;
        step_cycle();
        check_eq("switch_blank", 32'(segments), 32'h0);
        step_cycle();
        check_eq("first_glyph", 32'(segments), 32'(7'b0111111));

        // Ten ticks land on edge 41 after release.
        run_cycles(39);
        run = 1'b0;
        run_cycles(8);
        check_eq("dec_ticks10", 32'(ticks_seen), 32'd10);
        check_eq("dec10_d1", 32'(shown[1]), 32'(7'b0000110));
        check_eq("dec10_d0", 32'(shown[0]), 32'(7'b0111111));

        run = 1'b1;
        for (int i = 0; i < 2000 && ticks_seen < 100; i++) step_cycle();
        check_eq("dec_ticks100", 32'(ticks_seen), 32'd100);
        run = 1'b0;
        run_cycles(8);
        check_eq("wrap_d1", 32'(shown[1]), 32'(7'b0111111));
        check_eq("wrap_d0", 32'(shown[0]), 32'(7'b0111111));

        run = 1'b1;
        for (int i = 0; i < 1000 && ticks_seen < 137; i++) step_cycle();
        run = 1'b0;
        run_cycles(8);
        check_eq("cnt37_d1", 32'(shown[1]), 32'(7'b1001111));
        check_eq("cnt37_d0", 32'(shown[0]), 32'(7'b0000111));

        dir = 1'b0;
        run = 1'b1;
        async_reset();
        step_cycle();
        step_cycle();
        check_eq("restart_00", 32'(segments), 32'(7'b0111111));
        run_cycles(3);
        check_eq("rev_first_tick", 32'(frame_tick), 32'h1);
        check_eq("rev_99", 32'(segments), 32'(7'b1101111));

        dir = 1'b1;
        animation = 3'd2;
        nb = 0;
        for (int i = 0; i < 7; i++) got_b[i] = 7'h00;
        for (int i = 0; i < 200 && nb < 7; i++) begin
            step_cycle();
            if (frame_tick) begin
                got_b[nb] = segments;
                nb++;
            end
        end
        check_eq("bounce_ticks", 32'(nb), 32'd7);
        for (int i = 0; i < 7; i++) check_eq($sformatf("bounce_%0d", i), 32'(got_b[i]), 32'(exp_b[i]));

        animation = 3'd0;
        run_cycles(2);
        dir = 1'b0;
        animation = 3'd2;
        base = ticks_seen;
        for (int i = 0; i < 100 && ticks_seen == base; i++) step_cycle();
        check_eq("bounce_rev_first", 32'(segments), 32'(7'b0100010));

        dir = 1'b1;
        animation = 3'd1;
        base = ticks_seen;
        for (int i = 0; i < 100 && ticks_seen == base; i++) step_cycle();
        check_eq("ring_tick_seen", 32'(ticks_seen - base), 32'd1);
        run_cycles(3);
        animation = 3'd3;
        step_cycle();
        check_eq("chg_no_tick", 32'(frame_tick), 32'h0);
        step_cycle();
        check_eq("chg_blank", 32'(segments), 32'h0);
        step_cycle();
        check_eq("chg_blink_on", 32'(segments), 32'h7f);
        run = 1'b0;
        base = ticks_seen;
        run_cycles(20);
        check_eq("hold_no_tick", 32'(ticks_seen - base), 32'd0);
        check_eq("hold_pattern", 32'(segments), 32'h7f);

        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) animation = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 127) == 0) speed = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) async_reset();
            step_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
